intadd_opnd_collect: RTL

Operand-collection stage that sits directly upstream of the 4-lane 32-bit SIMD integer adder in the SMC intadd path. It takes 32-bit lane writes from the register-file read bus and assembles them into two 128-bit operands plus per-operand sign flags. Once both operands and the config are complete, it presents them to the adder through a valid/ready handshake. Operands are held stable until the consumer accepts them.

---
 rtl/intadd_opnd_collect.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/intadd_opnd_collect.sv
// ---------------------------------------------------------------------------
// intadd_opnd_collect
//
// Operand-collection stage in front of the 4-lane SIMD integer adder. Lane
// writes from the register-file read bus are assembled into two operands
// (src0/src1). The src0/src1 sign flags come from a separate config beat.
// Once every lane and the config have arrived, the stage enters ISSUE and
// holds the operands until the adder accepts them through a valid/ready
// handshake.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   flush           abort the current collection (data registers retained)
//   wr_en/wr_sel/wr_lane/wr_data
//                   lane write: operand select, lane index, lane data
//   cfg_valid/cfg_ready/cfg_sign_s0/cfg_sign_s1
//                   sign configuration beat
//   out_valid/out_ready/src0/src1/sign_s0/sign_s1
//                   operand handoff to the adder
//   busy            any lane or config collected, or operands pending
//   err_overwrite   pulse: an already-filled lane was written again
//   err_drop        pulse: a write or config arrived during ISSUE
//   issue_cnt       completed handshakes, wrapping
//
// Every output is a register or a decode of registered state. No input
// reaches an output in the same cycle.
// ---------------------------------------------------------------------------
module intadd_opnd_collect #(
  parameter int LANES = 4,
  parameter int LW    = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [1:0]            wr_lane,
  input  logic [LW-1:0]         wr_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_sign_s0,
  input  logic                  cfg_sign_s1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LW-1:0]   src0,
  output logic [LANES*LW-1:0]   src1,
  output logic                  sign_s0,
  output logic                  sign_s1,
  output logic                  busy,
  output logic                  err_overwrite,
  output logic                  err_drop,
  output logic [CNT_W-1:0]      issue_cnt
);

  localparam int MW = 2 * LANES;
  localparam int DW = LANES * LW;

  typedef enum logic {
    COLLECT = 1'b0,
    ISSUE   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [MW-1:0]     mask_q, mask_d;
  logic              cfg_seen_q, cfg_seen_d;
  logic [DW-1:0]     src0_q, src1_q;
  logic              sign_s0_q, sign_s1_q;
  logic              out_valid_q;
  logic              err_overwrite_q, err_drop_q;
  logic [CNT_W-1:0]  issue_cnt_q;

  // Per-cycle decisions made by the next-state logic.
  logic              wr_acc, cfg_acc, ovw_d, drop_d, cnt_inc;
  logic [2:0]        widx;

  // Mask bit layout: bits [LANES-1:0] are src0 lanes, the upper half src1.
  assign widx = {wr_sel, wr_lane};

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cfg_seen_d = cfg_seen_q;
    wr_acc     = 1'b0;
    cfg_acc    = 1'b0;
    ovw_d      = 1'b0;
    drop_d     = 1'b0;
    cnt_inc    = 1'b0;

    if (flush) begin
      // Flush wins over any same-cycle write, config or handshake, silently.
      state_d    = COLLECT;
      mask_d     = '0;
      cfg_seen_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          wr_acc  = wr_en;
          cfg_acc = cfg_valid;
          if (wr_en) begin
            ovw_d        = mask_q[widx];
            mask_d[widx] = 1'b1;
          end
          if (cfg_valid) cfg_seen_d = 1'b1;
          // Completion looks at the post-update mask so the final write and
          // a config in the same cycle both count.
          if ((&mask_d) && cfg_seen_d) state_d = ISSUE;
        end
        ISSUE: begin
          drop_d = wr_en | cfg_valid;
          if (out_ready) begin
            state_d    = COLLECT;
            mask_d     = '0;
            cfg_seen_d = 1'b0;
            cnt_inc    = 1'b1;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= COLLECT;
      mask_q          <= '0;
      cfg_seen_q      <= 1'b0;
      src0_q          <= '0;
      src1_q          <= '0;
      sign_s0_q       <= 1'b0;
      sign_s1_q       <= 1'b0;
      out_valid_q     <= 1'b0;
      err_overwrite_q <= 1'b0;
      err_drop_q      <= 1'b0;
      issue_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      cfg_seen_q      <= cfg_seen_d;
      out_valid_q     <= (state_d == ISSUE);
      err_overwrite_q <= ovw_d;
      err_drop_q      <= drop_d;
      // Operand and sign registers are only written by accepted beats; they
      // keep their contents across handshakes and flushes.
      if (wr_acc) begin
        if (wr_sel) src1_q[int'(wr_lane)*LW +: LW] <= wr_data;
        else        src0_q[int'(wr_lane)*LW +: LW] <= wr_data;
      end
      if (cfg_acc) begin
        sign_s0_q <= cfg_sign_s0;
        sign_s1_q <= cfg_sign_s1;
      end
      if (cnt_inc) issue_cnt_q <= issue_cnt_q + 1'b1;
    end
  end

  assign cfg_ready     = (state_q == COLLECT);
  assign busy          = (state_q == ISSUE) || (|mask_q) || cfg_seen_q;
  assign out_valid     = out_valid_q;
  assign src0          = src0_q;
  assign src1          = src1_q;
  assign sign_s0       = sign_s0_q;
  assign sign_s1       = sign_s1_q;
  assign err_overwrite = err_overwrite_q;
  assign err_drop      = err_drop_q;
  assign issue_cnt     = issue_cnt_q;

endmodule
